regfile_wb_arbiter: RTL and testbench

//  Shares the single register-file write port between NREQ writeback sources
//  (e.g. ALU, LSU, MUL/DIV). Round-robin arbitration, valid/ready handshake per

---
 rtl/regfile_wb_arbiter.sv | 75 +++++++
 tb/tb_regfile_wb_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the single register-file write port between NREQ writeback sources.
// Registered write-port outputs; x0 writes are accepted but never raise rd_we_o.
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int XLEN = 32,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [NREQ*5-1:0]    req_rd_a_i,
    input  logic [NREQ*XLEN-1:0] req_rd_d_i,
    input  logic                 stall_i,
    output logic                 rd_we_o,
    output logic [4:0]           rd_a_o,
    output logic [XLEN-1:0]      rd_d_o,
    output logic [IDW-1:0]       grant_id_o
);

    logic [IDW-1:0]  rr_ptr;
    logic            gnt_valid;
    logic [IDW-1:0]  gnt_idx;
    logic [4:0]      gnt_a;
    logic [XLEN-1:0] gnt_d;

    function automatic int wrap_idx(input int base, input int off);
        int sum;
        sum = base + off;
        return (sum >= NREQ) ? sum - NREQ : sum;
    endfunction

    // Search starts just after the last winner, so the last winner is lowest priority.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        req_ready_o = '0;
        gnt_valid   = 1'b0;
        gnt_idx     = '0;
        gnt_a       = '0;
        gnt_d       = '0;
        if (rst_ni && !stall_i) begin
            for (int k = 1; k <= NREQ; k++) begin
                if (!gnt_valid && req_valid_i[wrap_idx(int'(rr_ptr), k)]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = IDW'(wrap_idx(int'(rr_ptr), k));
                    gnt_a     = req_rd_a_i[5*wrap_idx(int'(rr_ptr), k) +: 5];
                    gnt_d     = req_rd_d_i[XLEN*wrap_idx(int'(rr_ptr), k) +: XLEN];
                end
            end
            if (gnt_valid) begin
                req_ready_o[gnt_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr     <= IDW'(NREQ - 1);
            rd_we_o    <= 1'b0;
            rd_a_o     <= '0;
            rd_d_o     <= '0;
            grant_id_o <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            rd_we_o <= gnt_valid && (gnt_a != 5'd0);
            if (gnt_valid) begin
                rr_ptr     <= gnt_idx;
                rd_a_o     <= gnt_a;
                rd_d_o     <= gnt_d;
                grant_id_o <= gnt_idx;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: stimulus pushes expected writes into a queue,
// a negedge monitor pops and compares whenever a handshake was seen in the previous cycle.
module tb_regfile_wb_arbiter;

    localparam int NREQ = 3;
    localparam int XLEN = 32;
    localparam int IDW  = 2;

    typedef struct {
        logic            we;
        logic [4:0]      a;
        logic [XLEN-1:0] d;
        logic [IDW-1:0]  id;
    } wr_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*5-1:0]    req_rd_a;
    logic [NREQ*XLEN-1:0] req_rd_d;
    logic                 stall = 1'b0;
    logic                 rd_we;
    logic [4:0]           rd_a;
    logic [XLEN-1:0]      rd_d;
    logic [IDW-1:0]       grant_id;

    logic [4:0]      src_a [NREQ];
    logic [XLEN-1:0] src_d [NREQ];

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    bit  drop   = 1'b0;

    always #5 clk = ~clk;

    always_comb begin
        req_rd_a = '0;
        req_rd_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_rd_a[5*i +: 5]       = src_a[i];
            req_rd_d[XLEN*i +: XLEN] = src_d[i];
        end
    end

    regfile_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .IDW(IDW)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_rd_a_i  (req_rd_a),
        .req_rd_d_i  (req_rd_d),
        .stall_i     (stall),
        .rd_we_o     (rd_we),
        .rd_a_o      (rd_a),
        .rd_d_o      (rd_d),
        .grant_id_o  (grant_id)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic we, input logic [4:0] a, input logic [XLEN-1:0] d,
                        input logic [IDW-1:0] id);
        wr_t e;
        e.we = we;
        e.a  = a;
        e.d  = d;
        e.id = id;
        exp_q.push_back(e);
    endtask

    task automatic chk_ready(input logic [NREQ-1:0] exp);
        #1;
        check("req_ready", 32'(req_ready), 32'(exp));
    endtask

    task automatic set_src(input int i, input logic [4:0] a, input logic [XLEN-1:0] d);
        src_a[i] = a;
        src_d[i] = d;
    endtask

    always @(negedge rst_n) drop = 1'b1;

    // Monitor: compare the registered write port against the queue, or check idle hold.
    initial begin
        bit  pending;
        wr_t last;
        wr_t e;
        pending = 1'b0;
        last = '{we: 1'b0, a: '0, d: '0, id: '0};
        forever begin
            @(negedge clk);
            if (drop) begin
                pending = 1'b0;
                last = '{we: 1'b0, a: '0, d: '0, id: '0};
                drop = 1'b0;
            end
            if (!rst_n) begin
                pending = 1'b0;
                continue;
            end
            if (pending) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_write", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_we", 32'(rd_we), 32'(e.we));
                    check("rd_a", 32'(rd_a), 32'(e.a));
                    check("rd_d", rd_d, e.d);
                    check("grant_id", 32'(grant_id), 32'(e.id));
                    last = e;
                end
            end else begin
                check("idle_rd_we", 32'(rd_we), 32'd0);
                check("hold_rd_a", 32'(rd_a), 32'(last.a));
                check("hold_rd_d", rd_d, last.d);
                check("hold_grant_id", 32'(grant_id), 32'(last.id));
            end
            check("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
            pending = |(req_valid & req_ready);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < NREQ; i++) set_src(i, 5'd0, '0);
        repeat (2) @(posedge clk);
        #1;
        // Reset values with all sources requesting
        set_src(0, 5'd1, 32'h1111_0001);
        set_src(1, 5'd2, 32'h2222_0002);
        set_src(2, 5'd3, 32'h3333_0003);
        req_valid = 3'b111;
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_rd_we", 32'(rd_we), 32'd0);
        check("rst_rd_a", 32'(rd_a), 32'd0);
        check("rst_rd_d", rd_d, 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);

        // Release mid-cycle: requester 0 wins first
        tick(); rst_n = 1'b1;
        push(1'b1, 5'd1, 32'h1111_0001, 2'd0); chk_ready(3'b001);
        tick(); req_valid = 3'b110;
        push(1'b1, 5'd2, 32'h2222_0002, 2'd1); chk_ready(3'b010);
        tick(); req_valid = 3'b100;
        push(1'b1, 5'd3, 32'h3333_0003, 2'd2); chk_ready(3'b100);
        tick(); req_valid = 3'b000; chk_ready(3'b000);

        // Single source
        tick(); req_valid = 3'b010; set_src(1, 5'd5, 32'hDEAD_BEEF);
        push(1'b1, 5'd5, 32'hDEAD_BEEF, 2'd1); chk_ready(3'b010);
        tick(); req_valid = 3'b000;

        // x0 write: accepted, no write enable
        tick(); req_valid = 3'b100; set_src(2, 5'd0, 32'h0000_1234);
        push(1'b0, 5'd0, 32'h0000_1234, 2'd2); chk_ready(3'b100);
        tick(); req_valid = 3'b000;

        // Contention: rr_ptr=2 so grants 0,1,2,0,1,2
        tick();
        set_src(0, 5'd7, 32'hA0A0_0007);
        set_src(1, 5'd8, 32'hB1B1_0008);
        set_src(2, 5'd9, 32'hC2C2_0009);
        req_valid = 3'b111;
        push(1'b1, 5'd7, 32'hA0A0_0007, 2'd0); chk_ready(3'b001);
        tick(); push(1'b1, 5'd8, 32'hB1B1_0008, 2'd1); chk_ready(3'b010);
        tick(); push(1'b1, 5'd9, 32'hC2C2_0009, 2'd2); chk_ready(3'b100);
        tick(); push(1'b1, 5'd7, 32'hA0A0_0007, 2'd0); chk_ready(3'b001);
        tick(); push(1'b1, 5'd8, 32'hB1B1_0008, 2'd1); chk_ready(3'b010);
        tick(); push(1'b1, 5'd9, 32'hC2C2_0009, 2'd2); chk_ready(3'b100);
        tick(); req_valid = 3'b000;

        // Stall two cycles; rr_ptr stays 2 so requester 0 goes first afterwards
        tick();
        set_src(0, 5'd13, 32'h0D0D_000D);
        set_src(1, 5'd14, 32'h0E0E_000E);
        req_valid = 3'b011; stall = 1'b1; chk_ready(3'b000);
        tick(); chk_ready(3'b000);
        tick(); stall = 1'b0;
        push(1'b1, 5'd13, 32'h0D0D_000D, 2'd0); chk_ready(3'b001);
        tick(); req_valid = 3'b010;
        push(1'b1, 5'd14, 32'h0E0E_000E, 2'd1); chk_ready(3'b010);

        // Reset mid-op: grant of 2 is dropped, then re-granted from 0
        tick();
        set_src(0, 5'd10, 32'h1010_000A);
        set_src(1, 5'd11, 32'h1111_000B);
        set_src(2, 5'd12, 32'h1212_000C);
        req_valid = 3'b111; chk_ready(3'b100);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midrst_rd_we", 32'(rd_we), 32'd0);
        check("midrst_ready", 32'(req_ready), 32'd0);
        tick(); rst_n = 1'b1;
        push(1'b1, 5'd10, 32'h1010_000A, 2'd0); chk_ready(3'b001);
        tick(); req_valid = 3'b110;
        push(1'b1, 5'd11, 32'h1111_000B, 2'd1); chk_ready(3'b010);
        tick(); req_valid = 3'b100;
        push(1'b1, 5'd12, 32'h1212_000C, 2'd2); chk_ready(3'b100);
        tick(); req_valid = 3'b000;
        repeat (3) tick();

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
